// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with a valid/ready handshake,
// an optional two-entry skid buffer, synchronous flush to a bubble pattern and
// saturating stall/flush debug counters.
module pipe_stage_reg #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               SKID   = 1,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic [WIDTH-1:0] skid_d;
      logic             in_ready_q;

      // The head always lives in main; skid only holds the second entry.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                main_d  = in_data;
                state_d = ONE;
              end
            end
            ONE: begin
              if (accept && pop) begin
                main_d = in_data;
              end else if (accept) begin
                skid_d  = in_data;
                state_d = FULL;
              end else if (pop) begin
                main_d  = BUBBLE;
                state_d = EMPTY;
              end
            end
            FULL: begin
              if (pop) begin
                main_d  = skid_q;
                skid_d  = BUBBLE;
                state_d = ONE;
              end
            end
            default: begin
              state_d = EMPTY;
              main_d  = BUBBLE;
              skid_d  = BUBBLE;
            end
          endcase
        end
      end

      // in_ready is registered from the next state, cutting the out_ready->in_ready path.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= EMPTY;
          main_q     <= BUBBLE;
          skid_q     <= BUBBLE;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= (state_d != FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      // With a combinational in_ready, an accept in ONE always coincides with a pop.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                main_d  = in_data;
                state_d = ONE;
              end
            end
            ONE: begin
              if (accept) begin
                main_d = in_data;
              end else if (pop) begin
                main_d  = BUBBLE;
                state_d = EMPTY;
              end
            end
            default: begin
              state_d = EMPTY;
              main_d  = BUBBLE;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= EMPTY;
          main_q  <= BUBBLE;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end

      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Debug counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, non-skid mode and a narrow
// counter instance, all checked against hand-computed values.
module tb_pipe_stage_reg;

  logic clk;

  // Instance A: SKID=1, WIDTH=8, BUBBLE=8'h13, CNT_W=16
  logic       a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic [15:0] a_stall, a_flushc;

  // Instance B: SKID=0
  logic       b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic [15:0] b_stall, b_flushc;

  // Instance C: SKID=1, CNT_W=3
  logic       c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [1:0] c_occ;
  logic [2:0] c_stall, c_flushc;

  int checks = 0;
  int fails  = 0;

  pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'h13), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall), .flush_cnt(a_flushc)
  );

  pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'h13), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall), .flush_cnt(b_flushc)
  );

  pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'h13), .SKID(1), .CNT_W(3)) dut_c (
    .clk(clk), .rst(c_rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .stall_cnt(c_stall), .flush_cnt(c_flushc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic ready, input logic flsh);
    a_in_valid  = valid;
    a_in_data   = data;
    a_out_ready = ready;
    a_flush     = flsh;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;

    // 1. Reset with junk on the input
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(a_out_valid), 32'h0);
    checkOutput("rst_out_data",  32'(a_out_data),  32'h13);
    checkOutput("rst_occ",       32'(a_occ),       32'h0);
    checkOutput("rst_stall",     32'(a_stall),     32'h0);
    checkOutput("rst_flushc",    32'(a_flushc),    32'h0);
    a_rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rst_in_ready",  32'(a_in_ready),  32'h1);
    checkOutput("rst_idle_valid", 32'(a_out_valid), 32'h0);

    // 2. Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      checkOutput("stream_in_ready", 32'(a_in_ready), 32'h1);
      tick();
      checkOutput("stream_valid", 32'(a_out_valid), 32'h1);
      checkOutput("stream_data",  32'(a_out_data),  32'(i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("stream_drained", 32'(a_out_valid), 32'h0);
    checkOutput("stream_stall",   32'(a_stall),     32'h0);

    // 3. Backpressure into the skid entry
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
    tick();
    checkOutput("bp_one_ready", 32'(a_in_ready), 32'h1);
    applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
    tick();
    checkOutput("bp_full_ready", 32'(a_in_ready), 32'h0);
    checkOutput("bp_full_occ",   32'(a_occ),      32'h2);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_data", 32'(a_out_data), 32'hA1);
    end
    checkOutput("bp_stall6", 32'(a_stall), 32'd6);
    checkOutput("bp_hold_occ", 32'(a_occ), 32'h2);
    applyStimulus(1'b1, 8'hA3, 1'b1, 1'b0);
    tick();
    checkOutput("bp_deq_a2",    32'(a_out_data), 32'hA2);
    checkOutput("bp_ready_back", 32'(a_in_ready), 32'h1);
    tick();
    checkOutput("bp_deq_a3", 32'(a_out_data), 32'hA3);
    checkOutput("bp_occ1",   32'(a_occ),      32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("bp_empty", 32'(a_out_valid), 32'h0);
    checkOutput("bp_stall_final", 32'(a_stall), 32'd6);

    // 4. Flush while full; B3 on the input must be dropped
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    tick();
    checkOutput("fl_pre_occ", 32'(a_occ), 32'h2);
    applyStimulus(1'b1, 8'hB3, 1'b0, 1'b1);
    tick();
    checkOutput("fl_valid",  32'(a_out_valid), 32'h0);
    checkOutput("fl_data",   32'(a_out_data),  32'h13);
    checkOutput("fl_occ",    32'(a_occ),       32'h0);
    checkOutput("fl_cnt",    32'(a_flushc),    32'h1);
    checkOutput("fl_ready",  32'(a_in_ready),  32'h1);
    checkOutput("fl_stall",  32'(a_stall),     32'd8);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("fl_no_b3", 32'(a_out_valid), 32'h0);
    end

    // 5. SKID=0: combinational in_ready
    b_rst = 1'b0;
    b_in_valid = 1'b1; b_in_data = 8'h55; b_out_ready = 1'b0;
    #1;
    checkOutput("ns_empty_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_in_data = 8'h66;
    #1;
    checkOutput("ns_held_ready", 32'(b_in_ready), 32'h0);
    checkOutput("ns_occ1",       32'(b_occ),      32'h1);
    tick();
    checkOutput("ns_hold_data", 32'(b_out_data), 32'h55);
    b_out_ready = 1'b1;
    #1;
    checkOutput("ns_comb_ready", 32'(b_in_ready), 32'h1);
    tick();
    checkOutput("ns_pass_data", 32'(b_out_data), 32'h66);
    checkOutput("ns_pass_occ",  32'(b_occ),      32'h1);
    b_in_valid = 1'b0;
    tick();
    checkOutput("ns_drain_occ",  32'(b_occ),      32'h0);
    checkOutput("ns_drain_data", 32'(b_out_data), 32'h13);

    // 6. Counter saturation at CNT_W=3
    c_rst = 1'b0;
    c_in_valid = 1'b1; c_in_data = 8'h77; c_out_ready = 1'b0;
    tick();
    c_in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checkOutput("sat_stall", 32'(c_stall), 32'd7);
    checkOutput("sat_data",  32'(c_out_data), 32'h77);
    for (int i = 0; i < 9; i++) begin
      c_flush = 1'b1;
      tick();
      c_flush = 1'b0;
      tick();
    end
    checkOutput("sat_flush", 32'(c_flushc), 32'd7);
    checkOutput("sat_stall_hold", 32'(c_stall), 32'd7);
    c_rst = 1'b1;
    tick();
    checkOutput("sat_rst_stall", 32'(c_stall),  32'h0);
    checkOutput("sat_rst_flush", 32'(c_flushc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing per-stage hand-written registers.
- Carries an opaque WIDTH-bit packed bundle, for example control, operand and address fields concatenated by the instantiating stage.
- Uses a valid/ready handshake instead of a stall bit.
- Optional two-entry skid buffer fully decouples ready paths between stages.
- Synchronous flush loads a parametrised bubble (NOP) pattern.
- Saturating stall and flush counters for performance debug.

Parameters:
WIDTH, 32, payload width in bits (>=1)
BUBBLE, '0, WIDTH-bit pattern loaded on reset/flush/drain (e.g. NOP control encoding)
SKID, 1, 1 = two-entry skid buffer, registered in_ready; 0 = single entry, combinational in_ready
CNT_W, 16, width of the stall_cnt and flush_cnt counters

Ports:
clk        input   1      clock, all state updates on posedge
rst        input   1      synchronous, active-high reset
flush      input   1      drop all held entries and the current input; load BUBBLE
in_valid   input   1      upstream has a bundle
in_ready   output  1      block accepts in_data this cycle
in_data    input   WIDTH  upstream bundle
out_valid  output  1      out_data holds a valid bundle
out_ready  input   1      downstream consumes out_data this cycle
out_data   output  WIDTH  head bundle; equals BUBBLE whenever out_valid=0
occupancy  output  2      entries held: 0, 1, or 2 (2 only when SKID=1)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  output  CNT_W  flush pulses seen, saturating

Behaviour:
- Handshake definitions:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
- Priority: rst > flush > normal operation.
- Reset: state EMPTY.
  - main=BUBBLE, skid=BUBBLE.
  - out_valid=0, out_data=BUBBLE, occupancy=0.
  - stall_cnt=0, flush_cnt=0.
  - in_ready=1 (SKID=1) or 1 combinationally (SKID=0).
- Flush (rst=0): next state EMPTY; main and skid <= BUBBLE.
  - in_data in the same cycle is discarded even if in_valid=1.
  - A pop in the same cycle still counts as consumed by downstream.
  - flush_cnt increments; stall_cnt is unaffected by flush except for that cycle's normal stall rule.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 bundle/cycle sustained when out_ready=1.
- out_data is driven directly from the main register (no combinational path from in_data).
- SKID=1 FSM, states EMPTY / ONE / FULL; occupancy = 0 / 1 / 2:
  - EMPTY: accept -> main<=in_data, ONE. Otherwise stay.
  - ONE, accept & pop -> main<=in_data, stay ONE.
  - ONE, accept & !pop -> skid<=in_data, FULL.
  - ONE, !accept & pop -> main<=BUBBLE, EMPTY.
  - ONE, neither -> hold.
  - FULL: pop -> main<=skid, skid<=BUBBLE, ONE. No accept is possible since in_ready=0.
  - in_ready is a flop, equal to (next state != FULL). No combinational path from out_ready to in_ready.
- SKID=0:
  - States EMPTY / ONE only; the skid register is not built.
  - in_ready = !out_valid | out_ready (combinational).
  - Transitions as above, with FULL unreachable.
- Entries leave in arrival order; no bundle is duplicated or lost except on flush.
- Held data is stable while out_valid=1 and out_ready=0.
- in_data is ignored when in_valid=0.
- Counters:
  - stall_cnt increments when out_valid & !out_ready.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - Cleared only by rst.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
1. Reset/bubble: WIDTH=8, BUBBLE=8'h13. Assert rst 2 cycles with in_valid=1, in_data=8'hAA -> out_valid=0, out_data=8'h13, occupancy=0, counters=0, in_ready=1 after release.
2. Streaming, SKID=1, out_ready=1: send 8'h01..8'h08 back-to-back -> out_data 01..08 each one cycle after accept, no gaps, in_ready stays 1, stall_cnt=0.
3. Backpressure/skid:
   - Send 8'hA1, 8'hA2, 8'hA3 with out_ready=0 -> A1, A2 accepted; in_ready=0 the cycle after A2; occupancy=2.
   - Hold 5 cycles -> stall_cnt=6 at end, out_data=A1 stable.
   - Raise out_ready -> A1, A2, A3 delivered in order.
4. Flush mid-FULL: occupancy=2 holding B1, B2. Pulse flush with in_valid=1, in_data=8'hB3 -> next cycle out_valid=0, out_data=8'h13, occupancy=0, flush_cnt=1. B3 never appears.
5. SKID=0 mode: out_ready=0 with one entry held -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally; simultaneous accept and pop keep occupancy=1.
6. Saturation: CNT_W=3. Hold stall for 12 cycles -> stall_cnt stops at 7. Pulse flush 9 times -> flush_cnt=7. rst -> both 0.
